// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Owns the single register-file write port and arbitrates writeback among
// the ALU, LSU and host/debug requesters. A per-register pending-write
// scoreboard is set when an instruction issues and cleared when its ALU or
// LSU result is written back. Decode reads it to stall RAW hazards.
//
// Arbitration: ALU > LSU > host by default. LSU and host each keep a
// starvation counter. A counter that has reached STARVE_LIMIT forces that
// requester to win over the ALU. A starved LSU beats a starved host.
// The host is only eligible when its destination is not busy. This prevents
// a host write from racing an in-flight producer (WAW).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_valid/rd/data, _ready  ALU writeback request / accept
//   lsu_valid/rd/data, _ready  load writeback request / accept
//   host_valid/rd/data, _ready host/debug write request / accept
//   issue_valid, issue_rd      instruction issued that will write issue_rd
//   rs1, rs2 -> rs1/rs2_busy   combinational scoreboard lookups for decode
//   reg_we, rd, rd_data        registered register-file write port
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int NREG         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,

    input  logic              host_valid,
    input  logic [ADDR_W-1:0] host_rd,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,

    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,

    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,

    output logic              reg_we,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] rd_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_set;
    logic [NREG-1:0]   busy_clr;
    logic [CNT_W-1:0]  lsu_cnt;
    logic [CNT_W-1:0]  host_cnt;

    logic              alu_elig;
    logic              lsu_elig;
    logic              host_elig;
    logic              grant_alu;
    logic              grant_lsu;
    logic              grant_host;
    logic              any_grant;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

    // -----------------------------------------------------------------------
    // Arbitration. Readies are held low during reset so that no handshake
    // can complete while the write port is being cleared.
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        alu_elig   = rst_n & alu_valid;
        lsu_elig   = rst_n & lsu_valid;
        host_elig  = rst_n & host_valid & ~busy[host_rd];

        grant_alu  = 1'b0;
        grant_lsu  = 1'b0;
        grant_host = 1'b0;

        if (lsu_elig && lsu_cnt == CNT_MAX) begin
            grant_lsu = 1'b1;
        end else if (host_elig && host_cnt == CNT_MAX) begin
            grant_host = 1'b1;
        end else if (alu_elig) begin
            grant_alu = 1'b1;
        end else if (lsu_elig) begin
            grant_lsu = 1'b1;
        end else if (host_elig) begin
            grant_host = 1'b1;
        end

        any_grant = grant_alu | grant_lsu | grant_host;

        win_rd   = '0;
        win_data = '0;
        if (grant_alu) begin
            win_rd   = alu_rd;
            win_data = alu_data;
        end else if (grant_lsu) begin
            win_rd   = lsu_rd;
            win_data = lsu_data;
        end else if (grant_host) begin
            win_rd   = host_rd;
            win_data = host_data;
        end
    end

    assign alu_ready  = grant_alu;
    assign lsu_ready  = grant_lsu;
    assign host_ready = grant_host;

    // -----------------------------------------------------------------------
    // Scoreboard update vectors. The set is applied after the clear, so an
    // issue and a writeback to the same register leave it busy (the issued
    // instruction is the newer producer). Host writes never clear.
    // -----------------------------------------------------------------------
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (issue_valid && issue_rd != '0) begin
            busy_set[issue_rd] = 1'b1;
        end
        if ((grant_alu || grant_lsu) && win_rd != '0) begin
            busy_clr[win_rd] = 1'b1;
        end
    end

    // Bit 0 is masked on every update so x0 can never read as busy.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~busy_clr) | busy_set) & {{(NREG-1){1'b1}}, 1'b0};
        end
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];

    // -----------------------------------------------------------------------
    // Starvation counters: count cycles eligible-but-not-granted, saturate,
    // clear on grant or when the requester drops out of eligibility.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_cnt  <= '0;
            host_cnt <= '0;
        end else begin
            if (!lsu_elig || grant_lsu) begin
                lsu_cnt <= '0;
            end else if (lsu_cnt != CNT_MAX) begin
                lsu_cnt <= lsu_cnt + CNT_W'(1);
            end

            if (!host_elig || grant_host) begin
                host_cnt <= '0;
            end else if (host_cnt != CNT_MAX) begin
                host_cnt <= host_cnt + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered write port. A grant to x0 completes the handshake but does
    // not pulse reg_we; rd/rd_data hold unless a real write is presented.
    // Async reset also discards a write that was queued for the next cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we  <= 1'b0;
            rd      <= '0;
            rd_data <= '0;
        end else begin
            reg_we <= any_grant && win_rd != '0;
            if (any_grant && win_rd != '0) begin
                rd      <= win_rd;
                rd_data <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed stimulus against rf_wb_arbiter. A behavioural model (integer
// counters, a busy-bit array, last-write record) predicts readies, scoreboard
// lookups and the write port. A negedge compare process checks every cycle.
// Hand-computed literal checks in the stimulus pin the model to the
// documented scenarios.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam int LIMIT  = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              alu_valid = 1'b0, lsu_valid = 1'b0, host_valid = 1'b0;
    logic [ADDR_W-1:0] alu_rd = '0, lsu_rd = '0, host_rd = '0;
    logic [DATA_W-1:0] alu_data = '0, lsu_data = '0, host_data = '0;
    logic              alu_ready, lsu_ready, host_ready;
    logic              issue_valid = 1'b0;
    logic [ADDR_W-1:0] issue_rd = '0;
    logic [ADDR_W-1:0] rs1 = '0, rs2 = '0;
    logic              rs1_busy, rs2_busy;
    logic              reg_we;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .host_valid(host_valid), .host_rd(host_rd), .host_data(host_data), .host_ready(host_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .reg_we(reg_we), .rd(rd), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_lsu_cnt  = 0;
    int          m_host_cnt = 0;
    bit          m_busy [NREG];
    bit          m_we    = 0;
    logic [ADDR_W-1:0] m_rd   = '0;
    logic [DATA_W-1:0] m_data = '0;
    bit          m_known = 1;

    // Who should win this cycle, from the documented rules.
    function automatic void m_arb(output bit ga, output bit gl, output bit gh);
        bit le = lsu_valid;
        bit he = host_valid && !m_busy[host_rd];
        ga = 0; gl = 0; gh = 0;
        if (le && m_lsu_cnt == LIMIT)       gl = 1;
        else if (he && m_host_cnt == LIMIT) gh = 1;
        else if (alu_valid)                 ga = 1;
        else if (le)                        gl = 1;
        else if (he)                        gh = 1;
    endfunction

    task automatic model_reset();
        m_lsu_cnt = 0; m_host_cnt = 0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
        m_we = 0; m_rd = '0; m_data = '0; m_known = 1;
    endtask

    task automatic model_step();
        bit ga, gl, gh, le, he;
        int w_rd;
        m_arb(ga, gl, gh);
        le = lsu_valid;
        he = host_valid && !m_busy[host_rd];
        m_lsu_cnt  = (gl || !le) ? 0 : ((m_lsu_cnt  < LIMIT) ? m_lsu_cnt  + 1 : LIMIT);
        m_host_cnt = (gh || !he) ? 0 : ((m_host_cnt < LIMIT) ? m_host_cnt + 1 : LIMIT);
        w_rd = ga ? int'(alu_rd) : gl ? int'(lsu_rd) : gh ? int'(host_rd) : 0;
        m_we = 0;
        if (ga || gl || gh) begin
            if (w_rd != 0) begin
                m_we = 1;
                m_rd = ADDR_W'(w_rd);
                m_data = ga ? alu_data : gl ? lsu_data : host_data;
                m_known = 1;
            end else begin
                m_known = 0;
            end
        end
        if ((ga || gl) && w_rd != 0) m_busy[w_rd] = 0;
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit ga, gl, gh;
        if (!rst_n) begin
            ga = 0; gl = 0; gh = 0;
        end else begin
            m_arb(ga, gl, gh);
        end
        check("cmp_alu_ready",  alu_ready,  ga);
        check("cmp_lsu_ready",  lsu_ready,  gl);
        check("cmp_host_ready", host_ready, gh);
        check("cmp_rs1_busy",   rs1_busy,   m_busy[rs1]);
        check("cmp_rs2_busy",   rs2_busy,   m_busy[rs2]);
        check("cmp_reg_we",     reg_we,     m_we);
        if (m_known) begin
            check("cmp_rd",      rd,      m_rd);
            check("cmp_rd_data", rd_data, m_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; lsu_valid = 0; host_valid = 0; issue_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        // Reset with all requesters active: nothing may be accepted.
        alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 2;
        host_valid = 1; host_rd = 4; rs1 = 7; rs2 = 3;
        tick(); tick();
        check("rst_alu_ready",  alu_ready,  0);
        check("rst_lsu_ready",  lsu_ready,  0);
        check("rst_host_ready", host_ready, 0);
        check("rst_reg_we",     reg_we,     0);
        check("rst_rd",         rd,         0);
        check("rst_rd_data",    rd_data,    0);
        check("rst_rs1_busy",   rs1_busy,   0);
        check("rst_rs2_busy",   rs2_busy,   0);
        idle();
        tick();
        rst_n = 1;
        tick();
        check("idle_reg_we", reg_we, 0);

        // ALU-only write, one-cycle latency, single pulse.
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 check("alu_ready", alu_ready, 1);
        tick(); idle();
        check("alu_we_n1",   reg_we,  1);
        check("alu_rd_n1",   rd,      5);
        check("alu_data_n1", rd_data, 32'hDEADBEEF);
        tick();
        check("alu_we_n2",   reg_we,  0);
        check("alu_hold_rd", rd,      5);

        // Scoreboard: issue 7 at c0, busy from c1, LSU writes 7 at c3.
        issue_valid = 1; issue_rd = 7; rs1 = 7;
        #1 check("sb_c0_busy", rs1_busy, 0);
        tick(); idle();
        check("sb_c1_busy", rs1_busy, 1);
        tick();
        check("sb_c2_busy", rs1_busy, 1);
        tick();
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_1234;
        #1 check("sb_c3_lsu_ready", lsu_ready, 1);
        check("sb_c3_busy", rs1_busy, 1);
        tick(); idle();
        check("sb_c4_busy", rs1_busy, 0);
        check("sb_c4_we",   reg_we,   1);
        check("sb_c4_rd",   rd,       7);
        check("sb_c4_data", rd_data,  32'h0000_1234);

        // Same-cycle set and clear of 7: set wins.
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 1; issue_rd = 7;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h7777_0007;
        tick(); idle();
        check("setclr_busy", rs1_busy, 1);
        check("setclr_we",   reg_we,   1);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h7777_0008;
        tick(); idle();
        tick();
        check("setclr_cleared", rs1_busy, 0);

        // Starvation ALU vs LSU: LSU wins on cycles 4 and 9.
        alu_valid = 1; alu_rd = 1; alu_data = 32'hA;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("starve_lsu_ready", lsu_ready, (k == 4 || k == 9) ? 1 : 0);
            check("starve_alu_ready", alu_ready, (k == 4 || k == 9) ? 0 : 1);
            tick();
        end
        idle();
        tick();

        // All three: LSU forced at c4, host (saturated count) at c5.
        alu_valid = 1; lsu_valid = 1; host_valid = 1;
        host_rd = 4; host_data = 32'hC;
        for (int k = 0; k < 12; k++) begin
            #1;
            check("starve3_host_ready", host_ready, (k == 5) ? 1 : 0);
            if (k == 5) host_valid = 0;
            tick();
        end
        idle();
        tick();

        // Host blocked by busy destination.
        issue_valid = 1; issue_rd = 3; rs2 = 3;
        tick(); idle();
        host_valid = 1; host_rd = 3; host_data = 32'h3333_0003;
        for (int k = 0; k < 6; k++) begin
            #1 check("host_blocked", host_ready, 0);
            tick();
        end
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h0000_0333;
        #1 check("host_blk_lsu_ready", lsu_ready, 1);
        check("host_blk_still", host_ready, 0);
        tick(); lsu_valid = 0;
        #1 check("host_unblocked", host_ready, 1);
        check("host_unblk_busy", rs2_busy, 0);
        tick(); idle();
        check("host_we", reg_we, 1);
        check("host_rd", rd,     3);

        // x0: handshake completes without a write.
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        issue_valid = 1; issue_rd = 0; rs1 = 0;
        #1 check("x0_alu_ready", alu_ready, 1);
        tick(); idle();
        check("x0_we",   reg_we,   0);
        check("x0_busy", rs1_busy, 0);

        // Reset in the cycle after a grant drops the write and the scoreboard.
        issue_valid = 1; issue_rd = 10; rs2 = 10;
        tick(); idle();
        check("rst2_busy_set", rs2_busy, 1);
        alu_valid = 1; alu_rd = 6; alu_data = 32'hAAAA_0006;
        tick(); idle();
        check("rst2_we_before", reg_we, 1);
        rst_n = 0;
        #1;
        check("rst2_we",   reg_we,   0);
        check("rst2_busy", rs2_busy, 0);
        check("rst2_rd",   rd,       0);
        check("rst2_data", rd_data,  0);
        tick(); tick();
        rst_n = 1;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
